stopwatch_timer: RTL
====================

Name: stopwatch_timer

Overview:
- Parametrised successor to the fixed MM:SS up-counter.
- Adds an internal tick prescaler, up/down direction, configurable minute ceiling with wrap or saturate, digit adjust with range clamping, run/pause and a terminal flag.
- Sits between the board clock and the seven-segment display driver; feeds it four BCD digits.

Parameters:
- TICK_DIV, 100000000, clk cycles per 1 s count tick; must be ≥2.
- MAX_MIN, 59, highest minutes value, 1..99.
- WRAP, 1, up-count at MAX_MIN:59: 1 = wrap to 00:00, 0 = saturate.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = count, 0 = pause; prescaler holds its value while paused.
- clr  in  1  synchronous clear to 00:00.
- dir  in  1  0 = count up, 1 = count down.
- adj  in  1  adjust mode; counting is suspended while high.
- adj_sel  in  2  digit select: 0 = min_l, 1 = min_r, 2 = sec_l, 3 = sec_r.
- adj_val  in  4  BCD value to load.
- lap  in  1  lap toggle pulse; used only with STOPWATCH_LAP_EN.
- tick  out  1  one-cycle pulse per count tick, asserted in the same cycle the digits update.
- min_l, min_r, sec_l, sec_r  out  4 each  BCD digits shown to the display.
- done  out  1  sticky terminal flag.

Behaviour:
- Reset (async, rst=1): all digits 0, prescaler 0, tick 0, done 0, lap freeze off.
- Priority each cycle: rst > clr > adj > tick.
- clr: digits 00:00, prescaler 0, done 0.
- Prescaler: increments when run=1 and adj=0. At TICK_DIV-1 it returns to 0, and the next edge registers tick=1 together with the digit update.
  - Count latency: TICK_DIV enabled cycles from clr to the first tick.
  - adj=1 clears the prescaler to 0.
- Up tick:
  - sec_r+1; at 10, sec_r=0 and sec_l+1.
  - sec_l at 6: sec_l=0 and minutes+1.
  - min_r at 10: min_r=0 and min_l+1.
  - At MAX_MIN:59 with WRAP=1: go to 00:00 and set done.
  - At MAX_MIN:59 with WRAP=0: hold the value, set done; tick still pulses.
- Down tick:
  - sec_r-1 with borrow: 0 goes to 9 and borrows from sec_l; sec_l 0 goes to 5 and borrows from minutes; min_r 0 goes to 9 and borrows from min_l.
  - A tick that lands on 00:00 sets done.
  - A tick at 00:00 holds 00:00; done stays 1.
  - Down never wraps.
- Changing dir takes effect on the next tick. The prescaler phase is kept.
- Adjust, each cycle adj=1:
  - The selected digit is loaded with adj_val clamped: sec_r and min_r to ≤9, sec_l to ≤5, min_l to ≤MAX_MIN/10.
  - If the resulting minutes exceed MAX_MIN, minutes are set to MAX_MIN.
  - done is cleared.
- Minutes width: two BCD digits, always; when MAX_MIN<10, min_l stays 0.
- done: set by the terminal events above. Cleared only by rst, clr or adj. The clearing action wins over a same-cycle set.
- All outputs are registered. Values outside 0..9 never appear on the digit outputs.

Optional Feature:
- STOPWATCH_LAP_EN defined:
  - A lap rising edge (lap is synchronous to clk) toggles freeze.
  - On entry to freeze, the digit outputs latch the current count; the internal count, tick and done keep running.
  - A second edge, clr or rst releases freeze; outputs then show the live count on the next cycle.
- Not defined: lap is ignored and the digit outputs always show the live count.

Decomposition:
- Package stopwatch_pkg:
  - bcd_t (4-bit digit type).
  - digit-select constants DIG_MIN_L=0, DIG_MIN_R=1, DIG_SEC_L=2, DIG_SEC_R=3.
  - DIR_UP=0, DIR_DOWN=1.
- One natural sub-module, bcd_digit:
  - parameter MOD (digit modulus).
  - inc/dec enable, carry/borrow out, synchronous load.
  - Instantiated four times; the MAX_MIN check lives in the parent.

Test Plan (TICK_DIV=4 unless stated):
- Up count, MAX_MIN=59, WRAP=1: run=1 from 00:00 for 4×60 cycles → 01:00; 40 ticks from 59:30 → 00:10, done=1.
- WRAP=0, MAX_MIN=5: adjust to 05:58, run 3 ticks → 05:59 held; done=1; tick still pulses every 4 cycles.
- Down: adjust to 01:00, dir=1, 1 tick → 00:59; 59 more ticks → 00:00 with done=1; a further tick holds 00:00.
- Adjust clamp: adj_sel=2, adj_val=9 → sec_l=5; MAX_MIN=59, adj_sel=0, adj_val=7 → min_l=5; clr and adj in the same cycle → 00:00.
- Pause/reset: run=0 after 2 prescaler cycles then resume → tick after exactly 2 more cycles; assert rst mid-count asynchronously → all outputs 0 before the next edge.
- STOPWATCH_LAP_EN: lap at 00:05, 3 ticks pass → outputs stay 00:05; second lap → 00:08.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch_timer block.
// Digit selects index the four display digits; the helpers convert a BCD
// pair into binary minutes and clamp an adjust value to a digit's limit.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] DIG_MIN_L = 2'd0;
    localparam logic [1:0] DIG_MIN_R = 2'd1;
    localparam logic [1:0] DIG_SEC_L = 2'd2;
    localparam logic [1:0] DIG_SEC_R = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Two BCD digits (tens, ones) to a binary value 0..99.
    function automatic logic [6:0] bcd2_to_bin(input bcd_t tens, input bcd_t ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

    // Limit a requested digit value to the highest legal value of that digit.
    function automatic bcd_t clamp_digit(input bcd_t val, input bcd_t lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/stopwatch_timer_bcd_digit.sv
// bcd_digit: one modulo-MOD BCD digit with increment, decrement and load.
// carry_o / borrow_o are lookahead flags (digit sits at its top / at zero),
// so the parent can build the ripple enables from register state only and
// the cascade contains no combinational loop. Load has priority over
// inc, inc over dec.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic inc_i,
    input  logic dec_i,
    output bcd_t q_o,
    output logic carry_o,
    output logic borrow_o
);

    localparam bcd_t MAX_VAL = bcd_t'(MOD - 1);

    bcd_t digit_q;
    bcd_t digit_d;

    assign q_o      = digit_q;
    assign carry_o  = (digit_q == MAX_VAL);
    assign borrow_o = (digit_q == 4'd0);

    // Next digit value: load, then modulo increment, then modulo decrement.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (inc_i) begin
            digit_d = (digit_q == MAX_VAL) ? 4'd0 : digit_q + 4'd1;
        end else if (dec_i) begin
            digit_d = (digit_q == 4'd0) ? MAX_VAL : digit_q - 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: MM:SS up/down counter with tick prescaler, minute
// ceiling (wrap or saturate), clamped digit adjust, run/pause and a sticky
// terminal flag. Optional lap-freeze display is enabled by defining
// STOPWATCH_LAP_EN; without it the lap input is ignored.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int MAX_MIN  = 59,
    parameter bit WRAP     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clr,
    input  logic       dir,
    input  logic       adj,
    input  logic [1:0] adj_sel,
    input  logic [3:0] adj_val,
    input  logic       lap,
    output logic       tick,
    output logic [3:0] min_l,
    output logic [3:0] min_r,
    output logic [3:0] sec_l,
    output logic [3:0] sec_r,
    output logic       done
);

    localparam int             PW          = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam bcd_t           MAX_MIN_T   = bcd_t'(MAX_MIN / 10);
    localparam bcd_t           MAX_MIN_O   = bcd_t'(MAX_MIN % 10);
    localparam logic [6:0]     MAX_MIN_BIN = 7'(MAX_MIN);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;
    logic          done_q;
    logic          done_d;

    bcd_t       dig_q    [4];
    bcd_t       adj_dig  [4];
    bcd_t       load_val [4];
    logic [3:0] load_v;
    logic [3:0] inc_v;
    logic [3:0] dec_v;
    logic [3:0] carry_v;
    logic [3:0] borrow_v;

    logic tick_en;
    logic count_up;
    logic count_dn;
    logic at_max;
    logic at_zero;
    logic land_zero;
    logic up_step;
    logic up_wrap;
    logic dn_step;

    // The minutes-tens digit never carries or borrows out; the ceiling and
    // the zero floor are handled by at_max / at_zero instead.
    logic unused_top_flags;
    assign unused_top_flags = carry_v[DIG_MIN_L] ^ borrow_v[DIG_MIN_L];

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        bcd_digit #(
            .MOD((gi == int'(DIG_SEC_L)) ? 6 : 10)
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load_v[gi]),
            .load_val_i(load_val[gi]),
            .inc_i     (inc_v[gi]),
            .dec_i     (dec_v[gi]),
            .q_o       (dig_q[gi]),
            .carry_o   (carry_v[gi]),
            .borrow_o  (borrow_v[gi])
        );
    end

    // A count tick fires on the edge where the enabled prescaler wraps.
    assign tick_en  = run && !adj && !clr && (presc_q == PRESC_LAST);
    assign count_up = tick_en && (dir == DIR_UP);
    assign count_dn = tick_en && (dir == DIR_DOWN);

    assign at_max = (dig_q[DIG_MIN_L] == MAX_MIN_T) && (dig_q[DIG_MIN_R] == MAX_MIN_O) &&
                    (dig_q[DIG_SEC_L] == 4'd5) && (dig_q[DIG_SEC_R] == 4'd9);
    assign at_zero = (dig_q[DIG_MIN_L] == 4'd0) && (dig_q[DIG_MIN_R] == 4'd0) &&
                     (dig_q[DIG_SEC_L] == 4'd0) && (dig_q[DIG_SEC_R] == 4'd0);
    // 00:01 is the only value a down tick turns into 00:00.
    assign land_zero = (dig_q[DIG_MIN_L] == 4'd0) && (dig_q[DIG_MIN_R] == 4'd0) &&
                       (dig_q[DIG_SEC_L] == 4'd0) && (dig_q[DIG_SEC_R] == 4'd1);

    assign up_step = count_up && !at_max;
    assign up_wrap = count_up && at_max && WRAP;
    assign dn_step = count_dn && !at_zero;

    // Prescaler: clears on clr/adj, counts while running, holds while paused.
    always_comb begin
        presc_d = presc_q;
        if (clr || adj) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // Adjusted digit set: load the selected digit clamped to its range, then
    // pull the minutes back to the ceiling if the pair overshoots it.
    always_comb begin
        adj_dig = dig_q;
        case (adj_sel)
            DIG_MIN_L: adj_dig[DIG_MIN_L] = clamp_digit(adj_val, MAX_MIN_T);
            DIG_MIN_R: adj_dig[DIG_MIN_R] = clamp_digit(adj_val, 4'd9);
            DIG_SEC_L: adj_dig[DIG_SEC_L] = clamp_digit(adj_val, 4'd5);
            default:   adj_dig[DIG_SEC_R] = clamp_digit(adj_val, 4'd9);
        endcase
        if (bcd2_to_bin(adj_dig[DIG_MIN_L], adj_dig[DIG_MIN_R]) > MAX_MIN_BIN) begin
            adj_dig[DIG_MIN_L] = MAX_MIN_T;
            adj_dig[DIG_MIN_R] = MAX_MIN_O;
        end
    end

    // Digit controls in priority order clr > adj > tick; carries ripple
    // through the lookahead flags of the lower digits.
    always_comb begin
        load_v   = '0;
        inc_v    = '0;
        dec_v    = '0;
        load_val = '{default: 4'd0};
        if (clr) begin
            load_v = '1;
        end else if (adj) begin
            load_v   = '1;
            load_val = adj_dig;
        end else if (up_wrap) begin
            load_v = '1;
        end else if (up_step) begin
            inc_v[DIG_SEC_R] = 1'b1;
            inc_v[DIG_SEC_L] = carry_v[DIG_SEC_R];
            inc_v[DIG_MIN_R] = carry_v[DIG_SEC_R] && carry_v[DIG_SEC_L];
            inc_v[DIG_MIN_L] = carry_v[DIG_SEC_R] && carry_v[DIG_SEC_L] && carry_v[DIG_MIN_R];
        end else if (dn_step) begin
            dec_v[DIG_SEC_R] = 1'b1;
            dec_v[DIG_SEC_L] = borrow_v[DIG_SEC_R];
            dec_v[DIG_MIN_R] = borrow_v[DIG_SEC_R] && borrow_v[DIG_SEC_L];
            dec_v[DIG_MIN_L] = borrow_v[DIG_SEC_R] && borrow_v[DIG_SEC_L] && borrow_v[DIG_MIN_R];
        end
    end

    // Tick pulse and sticky done flag; clearing beats a same-cycle set.
    always_comb begin
        tick_d = tick_en;
        done_d = done_q;
        if (clr || adj) begin
            done_d = 1'b0;
        end else if (count_up && at_max) begin
            done_d = 1'b1;
        end else if (count_dn && (land_zero || at_zero)) begin
            done_d = 1'b1;
        end
    end

    // Prescaler, tick and done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign tick = tick_q;
    assign done = done_q;

`ifdef STOPWATCH_LAP_EN
    logic lap_q;
    logic freeze_q;
    logic freeze_d;
    logic lap_rise;
    bcd_t frz_q [4];

    assign lap_rise = lap && !lap_q;

    // Freeze toggles on each lap rising edge; clr always releases it.
    always_comb begin
        freeze_d = freeze_q;
        if (clr) begin
            freeze_d = 1'b0;
        end else if (lap_rise) begin
            freeze_d = !freeze_q;
        end
    end

    // Lap edge detector, freeze flag and the snapshot taken on freeze entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q    <= 1'b0;
            freeze_q <= 1'b0;
            frz_q    <= '{default: 4'd0};
        end else begin
            lap_q    <= lap;
            freeze_q <= freeze_d;
            if (lap_rise && !freeze_q && !clr) begin
                frz_q <= dig_q;
            end
        end
    end

    // Display shows the snapshot while frozen, the live count otherwise.
    assign min_l = freeze_q ? frz_q[DIG_MIN_L] : dig_q[DIG_MIN_L];
    assign min_r = freeze_q ? frz_q[DIG_MIN_R] : dig_q[DIG_MIN_R];
    assign sec_l = freeze_q ? frz_q[DIG_SEC_L] : dig_q[DIG_SEC_L];
    assign sec_r = freeze_q ? frz_q[DIG_SEC_R] : dig_q[DIG_SEC_R];
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign min_l = dig_q[DIG_MIN_L];
    assign min_r = dig_q[DIG_MIN_R];
    assign sec_l = dig_q[DIG_SEC_L];
    assign sec_r = dig_q[DIG_SEC_R];
`endif

endmodule
